// File: rtl/negate_pkg.sv
// negate_pkg -- shared definitions for the negate_arbiter slice.
//   state_t        : FSM encoding (ST_IDLE = no result held, ST_RESP = result held)
//   PORT0 / PORT1  : requester ids (0 = ALU subtract operand, 1 = branch/jump offset)
//   DEFAULT_WIDTH  : default operand/result width
package negate_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2 -- combinational two-way round-robin grant.
// Ports:
//   valid0, valid1 : in  request present on port 0 / port 1
//   last           : in  port that won the previous accept
//   winner         : out port granted this cycle (PORT0 when nobody requests;
//                        callers qualify it with the VALIDs)
module rr_arbiter2
    import negate_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic winner
);

    // NOTE: every branch assigns winner, so always_comb infers pure logic
    // rather than a latch holding the previous value.
    always_comb begin
        if (valid0 && valid1) begin
            // On a tie the port that did not win last time gets its turn.
            winner = (last == PORT0) ? PORT1 : PORT0;
        end else if (valid1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
    end

endmodule

// File: rtl/negate_arbiter.sv
// negate_arbiter -- shares one two's-complement unit between two requesters
// (port 0: ALU subtract operand, port 1: branch/jump offset) with round-robin
// arbitration and a held, registered response.
// Optional feature macro: NEG_OVF_FLAG_EN (adds RSP_OVF, set when the most
// negative value is negated).
// Ports:
//   CLK, RESET_N            : clock, asynchronous active-low reset
//   REQx_VALID/DATA/NEG     : in  request, operand, 1 = negate / 0 = pass through
//   REQx_READY              : out request accepted on this edge when VALID & READY
//   RSPx_VALID              : out result pending for port x
//   RSPx_READY              : in  port x takes the result on this edge
//   RSP_DATA                : out shared result, qualified by RSPx_VALID
//   RSP_OVF                 : out overflow flag (NEG_OVF_FLAG_EN only)
module negate_arbiter
    import negate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ0_VALID,
    input  logic [WIDTH-1:0] REQ0_DATA,
    input  logic             REQ0_NEG,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic [WIDTH-1:0] REQ1_DATA,
    input  logic             REQ1_NEG,
    output logic             REQ1_READY,
    output logic             RSP0_VALID,
    input  logic             RSP0_READY,
    output logic             RSP1_VALID,
    input  logic             RSP1_READY,
    output logic [WIDTH-1:0] RSP_DATA
`ifdef NEG_OVF_FLAG_EN
    ,
    output logic             RSP_OVF
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic             owner;
    logic             last;
    logic             winner;
    logic             owner_ready;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_neg;
    logic [WIDTH-1:0] result;

    rr_arbiter2 u_arb (
        .valid0 (REQ0_VALID),
        .valid1 (REQ1_VALID),
        .last   (last),
        .winner (winner)
    );

    always_comb begin
        owner_ready = (owner == PORT1) ? RSP1_READY : RSP0_READY;
        // A new request may enter when nothing is held, or when the held result
        // leaves on this same edge (back-to-back, no idle bubble).
        can_accept  = (state == ST_IDLE) || owner_ready;
        REQ0_READY  = REQ0_VALID && (winner == PORT0) && can_accept;
        REQ1_READY  = REQ1_VALID && (winner == PORT1) && can_accept;
        accept      = REQ0_READY || REQ1_READY;
        sel_data    = (winner == PORT1) ? REQ1_DATA : REQ0_DATA;
        sel_neg     = (winner == PORT1) ? REQ1_NEG  : REQ0_NEG;
        // Result wraps at WIDTH: negating 0 gives 0, the most negative value maps to itself.
        result      = sel_neg ? (~sel_data + ONE) : sel_data;
    end

    // Valid flags decode straight from registered state, so they never glitch
    // on request-side inputs.
    assign RSP0_VALID = (state == ST_RESP) && (owner == PORT0);
    assign RSP1_VALID = (state == ST_RESP) && (owner == PORT1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            owner    <= PORT0;
            last     <= PORT1;   // port 0 wins the first tie after reset
            RSP_DATA <= '0;
        end else if (accept) begin
            state    <= ST_RESP;
            owner    <= winner;
            last     <= winner;
            RSP_DATA <= result;
        end else if ((state == ST_RESP) && owner_ready) begin
            state    <= ST_IDLE;
        end
    end

`ifdef NEG_OVF_FLAG_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RSP_OVF <= 1'b0;
        end else if (accept) begin
            RSP_OVF <= sel_neg && (sel_data == MOST_NEG);
        end
    end
`endif

endmodule

// File: tb/tb_negate_arbiter.sv
// tb_negate_arbiter -- randomized + directed bench for negate_arbiter.
// A driver applies one request set per cycle and predicts, from the grant
// rules, which port is accepted; accepted results go into a scoreboard queue.
// A separate monitor compares every cycle's RSP outputs against the queue head.
module tb_negate_arbiter;

    localparam int W = 8;

    typedef struct {
        logic         port;
        logic [W-1:0] data;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [W-1:0] req_data [2];
    logic [1:0]   req_neg = '0;
    logic [1:0]   rsp_ready = '0;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp_data;
    logic         rsp_ovf;

    int           n_checks = 0;
    int           n_fail   = 0;
    exp_t         sb[$];
    logic         last_m = 1'b1;
    logic [1:0]   acc_last = '0;

    always #5 clk = ~clk;

    negate_arbiter #(.WIDTH(W)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .REQ0_VALID (req_valid[0]),
        .REQ0_DATA  (req_data[0]),
        .REQ0_NEG   (req_neg[0]),
        .REQ0_READY (req0_ready),
        .REQ1_VALID (req_valid[1]),
        .REQ1_DATA  (req_data[1]),
        .REQ1_NEG   (req_neg[1]),
        .REQ1_READY (req1_ready),
        .RSP0_VALID (rsp0_valid),
        .RSP0_READY (rsp_ready[0]),
        .RSP1_VALID (rsp1_valid),
        .RSP1_READY (rsp_ready[1]),
        .RSP_DATA   (rsp_data)
`ifdef NEG_OVF_FLAG_EN
        ,
        .RSP_OVF    (rsp_ovf)
`endif
    );

`ifndef NEG_OVF_FLAG_EN
    assign rsp_ovf = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: two's complement computed as 2^W - x, modulo 2^W.
    function automatic exp_t model_result(input logic port, input logic [W-1:0] d, input logic n);
        exp_t e;
        int   op;
        op     = int'(d);
        e.port = port;
        e.data = n ? W'(((1 << W) - op) % (1 << W)) : d;
        e.ovf  = n && (op == (1 << (W - 1)));
        return e;
    endfunction

    // One bus cycle: drive at negedge, check READYs against the turn rules,
    // record the accepted transaction at the following posedge.
    task automatic drive_cycle(input logic v0, input logic [W-1:0] d0, input logic n0,
                               input logic v1, input logic [W-1:0] d1, input logic n1,
                               input logic r0, input logic r1);
        logic [1:0] exp_rdy;
        logic       win;
        logic       free;
        @(negedge clk);
        req_valid   = {v1, v0};
        req_data[0] = d0;
        req_data[1] = d1;
        req_neg     = {n1, n0};
        rsp_ready   = {r1, r0};
        #1;
        if (v0 && v1) win = ~last_m;
        else          win = v1;
        free    = (sb.size() == 0) || rsp_ready[sb[0].port];
        exp_rdy = '0;
        if ((v0 || v1) && free) exp_rdy[win] = 1'b1;
        check("req0_ready", 32'(req0_ready), 32'(exp_rdy[0]));
        check("req1_ready", 32'(req1_ready), 32'(exp_rdy[1]));
        acc_last = exp_rdy;
        @(posedge clk);
        if (exp_rdy != 2'b00) begin
            sb.push_back(model_result(win, req_data[win], req_neg[win]));
            last_m = win;
        end
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        sb.delete();
        last_m    = 1'b1;
        #1;
        check("async_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("async_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle, RSP outputs must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("rsp0_valid", 32'(rsp0_valid), 32'((sb.size() != 0) && (sb[0].port == 1'b0)));
            check("rsp1_valid", 32'(rsp1_valid), 32'((sb.size() != 0) && (sb[0].port == 1'b1)));
            if (sb.size() != 0) begin
                check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
`ifdef NEG_OVF_FLAG_EN
                check("rsp_ovf", 32'(rsp_ovf), 32'(sb[0].ovf));
`endif
                if (rsp_ready[sb[0].port]) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [1:0]   hv;
        logic [W-1:0] hd [2];
        logic [1:0]   hn;
        logic         r0, r1;

        req_data[0] = '0;
        req_data[1] = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
`ifdef NEG_OVF_FLAG_EN
        check("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
`endif
        req_valid[0] = 1'b1;
        #1;
        check("reset_req0_ready", 32'(req0_ready), 32'd1);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single negate: 0x05 -> 0xFB.
        drive_cycle(1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Both ports continuously requesting: alternating grants, no bubbles.
        repeat (6) drive_cycle(1'b1, 8'h01, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Port 1 result stalled for 3 cycles while port 0 waits.
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        repeat (3) drive_cycle(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Arithmetic corners: most negative value and zero.
        drive_cycle(1'b1, 8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Reset while a result is held, then a tie must go to port 0.
        drive_cycle(1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset_mid_op();
        drive_cycle(1'b1, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Randomized traffic; a pending request is held stable until accepted.
        hv       = '0;
        hn       = '0;
        hd[0]    = '0;
        hd[1]    = '0;
        acc_last = '0;
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(hv[p] && !acc_last[p])) begin
                    hv[p] = ($urandom_range(0, 9) < 7);
                    case ($urandom_range(0, 7))
                        0:       hd[p] = 8'h80;
                        1:       hd[p] = 8'h00;
                        default: hd[p] = 8'($urandom);
                    endcase
                    hn[p] = 1'($urandom);
                end
            end
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            drive_cycle(hv[0], hd[0], hn[0], hv[1], hd[1], hn[1], r0, r1);
        end

        // Drain whatever is still held.
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
